instr_decode: RTL
=================

INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 Parameter INSTR_W, default 32: instruction word width.
REQ-002 Parameter OPC_W, default 6: opcode width, taken from instr[INSTR_W-1 -: OPC_W].
REQ-003 Parameter REG_AW, default 5: register address width.
REQ-004 Parameter IMM_W, default 16: immediate width; ADDR_W, default 8: direct memory address width.
REQ-005 Parameter NUM_OPS, default 18: opcodes 0..NUM_OPS-1 legal; CNT_W, default 8: illegal counter width.
REQ-006 clk  in  1  sole clock; reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid in 1 / in_ready out 1 / instr in INSTR_W: fetch-side handshake and instruction word.
REQ-009 flush  in  1  discard the held output entry (branch redirect).
REQ-010 out_valid out 1 / out_ready in 1: execute-side handshake.
REQ-011 fmt  out  3  format: 0 IMM, 1 MOV, 2 LD, 3 ST, 4 ALU, 7 ILL.
REQ-012 opcode out OPC_W; rd2, rd1, rs2, rs1 out REG_AW each; imm out IMM_W; addr out ADDR_W.
REQ-013 we2, we1, re2, re1  out  1  write/read enables for rd2, rd1, rs2, rs1.
REQ-014 illegal_cnt  out  CNT_W  saturating count of accepted illegal opcodes.

Function
REQ-015 Fields: rd2 = bits directly below opcode; rd1 = next REG_AW below; rs2 = instr[2*REG_AW-1:REG_AW]; rs1 = instr[REG_AW-1:0].
REQ-016 Op 0 (IMM): rd2, imm = instr[IMM_W-1:0]; we2=1.
REQ-017 Op 1 (MOV): rd2, rs2 = instr[REG_AW-1:0]; we2=1, re2=1.
REQ-018 Op 2 (LD): rd2, addr = instr[ADDR_W-1:0]; we2=1.
REQ-019 Op 3 (ST): addr = ADDR_W bits directly below opcode, rs2 = instr[REG_AW-1:0]; re2=1.
REQ-020 Ops 4..NUM_OPS-1 (ALU): rd2, rd1, rs2, rs1 all valid; we2=we1=re2=re1=1.
REQ-021 Opcode >= NUM_OPS: fmt=7, all enables 0, all field outputs 0.
REQ-022 Unused field outputs for a legal format are driven 0.
REQ-023 Single output register stage; latency exactly 1 cycle from accept to out_valid.
REQ-024 Accept when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-025 Output entry and out_valid hold stable while out_valid && !out_ready.
REQ-026 Simultaneous drain and accept: new entry loaded, out_valid stays 1, no bubble.
REQ-027 flush: out_valid cleared next cycle; an instruction presented with flush is dropped; in_ready=1 while flush.
REQ-028 illegal_cnt increments on each accepted illegal opcode (not on flushed input), saturates at 2^CNT_W-1.

Reset
REQ-029 On rst: out_valid=0, fmt=0, all field outputs and enables 0, illegal_cnt=0.
REQ-030 rst mid-transfer discards the held entry; rst has priority over flush and accept.

Structure
REQ-031 Shared package holds format encodings, opcode constants OP_IMM=0, OP_MOV=1, OP_LD=2, OP_ST=3, OP_ALU_FIRST=4, and the decoded-bundle struct.
REQ-032 One combinational sub-module instr_field_extract (instr -> bundle); instr_decode adds the handshake register and counter.

Verification
REQ-033 instr=0x00201234, out_ready=1 -> next cycle fmt=0, rd2=1, imm=0x1234, we2=1, others 0.
REQ-034 instr=0x106200A7 -> fmt=4, rd2=3, rd1=2, rs2=5, rs1=7, all four enables 1.
REQ-035 instr=0x0EAC0009 -> fmt=3, addr=0xAB, rs2=9, re2=1, we2=0.
REQ-036 instr=0x48000000 (op 18) -> fmt=7, enables 0, illegal_cnt 0->1; 300 illegal accepts -> illegal_cnt=255.
REQ-037 out_ready=0 for 5 cycles with entry held -> outputs stable, in_ready=0; out_ready=1 with in_valid=1 -> back-to-back transfers, no bubble.
REQ-038 flush with held entry and in_valid=1 -> out_valid=0 next cycle, illegal_cnt unchanged; rst asserted mid-stall -> out_valid=0, illegal_cnt=0.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared types for the instruction decoder: format codes, opcode map and the
// decoded-instruction bundle passed from the field extractor to the output stage.
package instr_decode_pkg;

    typedef enum logic [2:0] {
        FMT_IMM = 3'd0,
        FMT_MOV = 3'd1,
        FMT_LD  = 3'd2,
        FMT_ST  = 3'd3,
        FMT_ALU = 3'd4,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam int OP_IMM       = 0;
    localparam int OP_MOV       = 1;
    localparam int OP_LD        = 2;
    localparam int OP_ST        = 3;
    localparam int OP_ALU_FIRST = 4;

    // The bundle is sized for the widest configuration we support; the decoder
    // fills the low bits and leaves the rest zero, so one type serves every
    // parameterisation of the top level.
    localparam int OPC_MAX_W  = 16;
    localparam int REG_MAX_W  = 8;
    localparam int IMM_MAX_W  = 32;
    localparam int ADDR_MAX_W = 32;

    typedef struct packed {
        fmt_e                   fmt;
        logic [OPC_MAX_W-1:0]   opcode;
        logic [REG_MAX_W-1:0]   rd2;
        logic [REG_MAX_W-1:0]   rd1;
        logic [REG_MAX_W-1:0]   rs2;
        logic [REG_MAX_W-1:0]   rs1;
        logic [IMM_MAX_W-1:0]   imm;
        logic [ADDR_MAX_W-1:0]  addr;
        logic                   we2;
        logic                   we1;
        logic                   re2;
        logic                   re1;
    } dec_bundle_t;

    function automatic logic is_illegal_fmt(input fmt_e f);
        return (f == FMT_ILL);
    endfunction

endpackage

// File: rtl/instr_field_extract.sv
// Purely combinational field extraction: instruction word in, decoded bundle out.
// Fields a format does not use are left at zero.
module instr_field_extract
    import instr_decode_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 6,
    parameter int REG_AW  = 5,
    parameter int IMM_W   = 16,
    parameter int ADDR_W  = 8,
    parameter int NUM_OPS = 18
) (
    input  logic [INSTR_W-1:0] i_instr,
    output dec_bundle_t        o_bundle
);

    localparam int RD2_LSB   = INSTR_W - OPC_W - REG_AW;
    localparam int RD1_LSB   = RD2_LSB - REG_AW;
    localparam int ADRHI_LSB = INSTR_W - OPC_W - ADDR_W;

    logic [OPC_W-1:0]  w_opc;
    logic [31:0]       w_opc_ext;
    logic [REG_AW-1:0] w_rd2;
    logic [REG_AW-1:0] w_rd1;
    logic [REG_AW-1:0] w_reg_hi;
    logic [REG_AW-1:0] w_reg_lo;
    logic [IMM_W-1:0]  w_imm;
    logic [ADDR_W-1:0] w_addr_lo;
    logic [ADDR_W-1:0] w_addr_hi;

    assign w_opc     = i_instr[INSTR_W-1 -: OPC_W];
    assign w_opc_ext = 32'(w_opc);
    assign w_rd2     = i_instr[RD2_LSB +: REG_AW];
    assign w_rd1     = i_instr[RD1_LSB +: REG_AW];
    assign w_reg_hi  = i_instr[2*REG_AW-1:REG_AW];
    assign w_reg_lo  = i_instr[REG_AW-1:0];
    assign w_imm     = i_instr[IMM_W-1:0];
    assign w_addr_lo = i_instr[ADDR_W-1:0];
    // Stores carry their address right under the opcode since they have no rd2.
    assign w_addr_hi = i_instr[ADRHI_LSB +: ADDR_W];

    // Select the fields and enables that the opcode's format defines.
    always_comb begin
        o_bundle        = '0;
        o_bundle.opcode = OPC_MAX_W'(w_opc);
        if (w_opc_ext >= 32'(NUM_OPS)) begin
            o_bundle.fmt = FMT_ILL;
        end else if (w_opc_ext >= 32'(OP_ALU_FIRST)) begin
            o_bundle.fmt = FMT_ALU;
            o_bundle.rd2 = REG_MAX_W'(w_rd2);
            o_bundle.rd1 = REG_MAX_W'(w_rd1);
            o_bundle.rs2 = REG_MAX_W'(w_reg_hi);
            o_bundle.rs1 = REG_MAX_W'(w_reg_lo);
            o_bundle.we2 = 1'b1;
            o_bundle.we1 = 1'b1;
            o_bundle.re2 = 1'b1;
            o_bundle.re1 = 1'b1;
        end else begin
            case (w_opc_ext)
                32'(OP_IMM): begin
                    o_bundle.fmt = FMT_IMM;
                    o_bundle.rd2 = REG_MAX_W'(w_rd2);
                    o_bundle.imm = IMM_MAX_W'(w_imm);
                    o_bundle.we2 = 1'b1;
                end
                32'(OP_MOV): begin
                    o_bundle.fmt = FMT_MOV;
                    o_bundle.rd2 = REG_MAX_W'(w_rd2);
                    o_bundle.rs2 = REG_MAX_W'(w_reg_lo);
                    o_bundle.we2 = 1'b1;
                    o_bundle.re2 = 1'b1;
                end
                32'(OP_LD): begin
                    o_bundle.fmt  = FMT_LD;
                    o_bundle.rd2  = REG_MAX_W'(w_rd2);
                    o_bundle.addr = ADDR_MAX_W'(w_addr_lo);
                    o_bundle.we2  = 1'b1;
                end
                default: begin
                    o_bundle.fmt  = FMT_ST;
                    o_bundle.addr = ADDR_MAX_W'(w_addr_hi);
                    o_bundle.rs2  = REG_MAX_W'(w_reg_lo);
                    o_bundle.re2  = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_decode.sv
// Instruction decoder: one registered output entry with valid/ready on both
// sides, a flush for branch redirects and a saturating illegal-opcode counter.
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 6,
    parameter int REG_AW  = 5,
    parameter int IMM_W   = 16,
    parameter int ADDR_W  = 8,
    parameter int NUM_OPS = 18,
    parameter int CNT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_flush,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [2:0]         o_fmt,
    output logic [OPC_W-1:0]   o_opcode,
    output logic [REG_AW-1:0]  o_rd2,
    output logic [REG_AW-1:0]  o_rd1,
    output logic [REG_AW-1:0]  o_rs2,
    output logic [REG_AW-1:0]  o_rs1,
    output logic [IMM_W-1:0]   o_imm,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_we2,
    output logic               o_we1,
    output logic               o_re2,
    output logic               o_re1,
    output logic [CNT_W-1:0]   o_illegal_cnt
);

    dec_bundle_t      w_bundle;
    logic             w_accept;
    logic             w_is_ill;
    logic             w_cnt_sat;
    logic             w_bundle_unused;

    dec_bundle_t      r_entry;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_illegal_cnt;

    instr_field_extract #(
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W),
        .REG_AW  (REG_AW),
        .IMM_W   (IMM_W),
        .ADDR_W  (ADDR_W),
        .NUM_OPS (NUM_OPS)
    ) u_extract (
        .i_instr  (i_instr),
        .o_bundle (w_bundle)
    );

    // A flush empties the stage this cycle, so upstream may always present then,
    // but whatever it presents alongside the flush is dropped.
    assign o_in_ready = i_flush | ~r_out_valid | i_out_ready;
    assign w_accept   = i_in_valid & o_in_ready & ~i_flush;
    assign w_is_ill   = is_illegal_fmt(w_bundle.fmt);
    assign w_cnt_sat  = &r_illegal_cnt;

    // Bundle bits above the configured widths are always zero; fold them here
    // so the narrower output slices do not leave dangling bits.
    assign w_bundle_unused = ^{w_bundle, r_entry};

    // Output entry: reset beats flush beats accept; otherwise drain on ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_entry     <= '0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_entry     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_entry     <= w_bundle;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Count accepted illegal opcodes, holding at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_illegal_cnt <= '0;
        end else if (w_accept && w_is_ill && !w_cnt_sat) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_fmt         = r_entry.fmt;
    assign o_opcode      = r_entry.opcode[OPC_W-1:0];
    assign o_rd2         = r_entry.rd2[REG_AW-1:0];
    assign o_rd1         = r_entry.rd1[REG_AW-1:0];
    assign o_rs2         = r_entry.rs2[REG_AW-1:0];
    assign o_rs1         = r_entry.rs1[REG_AW-1:0];
    assign o_imm         = r_entry.imm[IMM_W-1:0];
    assign o_addr        = r_entry.addr[ADDR_W-1:0];
    assign o_we2         = r_entry.we2;
    assign o_we1         = r_entry.we1;
    assign o_re2         = r_entry.re2;
    assign o_re1         = r_entry.re1;
    assign o_illegal_cnt = r_illegal_cnt;

endmodule
